// File: rtl/ppa_add_arbiter_pkg.sv
// ppa_arb_pkg: shared constants, ID-width helper and response-slot type for ppa_add_arbiter.
package ppa_arb_pkg;
    localparam int PPA_W = 49;
    localparam int PPA_IDW_MAX = 3;

    function automatic int ppa_idw(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef struct packed {
        logic [PPA_IDW_MAX-1:0] id;
        logic [PPA_W-1:0]       sum;
        logic                   cout;
    } ppa_rsp_t;
endpackage

// File: rtl/ppa_add_arbiter_if.sv
// ppa_add_arbiter_if: requester operand handshake plus response port of the shared-adder arbiter.
interface ppa_add_arbiter_if
    import ppa_arb_pkg::*;
#(
    parameter int W    = PPA_W,
    parameter int NREQ = 4,
    parameter int IDW  = ppa_idw(NREQ)
);
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic [NREQ-1:0]   req_chain;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [W-1:0]      rsp_sum;
    logic              rsp_cout;

    modport master (
        output req_valid, req_a, req_b, req_cin, req_chain, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );
    modport slave (
        input  req_valid, req_a, req_b, req_cin, req_chain, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );
endinterface

// File: rtl/PPA_Sklansky_49bit.sv
// PPA_Sklansky_49bit: 49-bit Sklansky (divide-and-conquer) parallel-prefix adder with carry-in.
module PPA_Sklansky_49bit (
    input  logic [48:0] i_a,
    input  logic [48:0] i_b,
    input  logic        i_cin,
    output logic [48:0] o_sum,
    output logic        o_cout
);
    logic [49:0] w_g, w_p, w_gn, w_pn;

    // position 0 carries cin, so the prefix at position i is the carry into bit i
    always_comb begin
        w_g  = {i_a & i_b, i_cin};
        w_p  = {i_a ^ i_b, 1'b0};
        w_gn = w_g;
        w_pn = w_p;
        for (int l = 0; l < 6; l++) begin
            w_gn = w_g;
            w_pn = w_p;
            for (int i = 1; i < 50; i++)
                if (i[l]) begin
                    w_gn[i] = w_g[i] | (w_p[i] & w_g[((i >> l) << l) - 1]);
                    w_pn[i] = w_p[i] & w_p[((i >> l) << l) - 1];
                end
            w_g = w_gn;
            w_p = w_pn;
        end
    end

    assign o_sum  = i_a ^ i_b ^ w_g[48:0];
    assign o_cout = w_g[49];
endmodule

// File: rtl/ppa_add_arbiter_rr.sv
// ppa_rr_arbiter: NREQ-way rotating-priority grant; first request at or after i_ptr wins.
module ppa_rr_arbiter
    import ppa_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = ppa_idw(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [IDW-1:0]  i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [IDW-1:0]  o_id,
    output logic            o_any
);
    int j;

    // scan downward so the lowest offset from the pointer is written last
    always_comb begin
        o_grant = '0;
        o_id    = '0;
        o_any   = |i_req;
        j       = 0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            j = int'(i_ptr) + k;
            j = (j >= NREQ) ? j - NREQ : j;
            if (i_req[j[IDW-1:0]]) begin
                o_grant = NREQ'(1) << j;
                o_id    = IDW'(j);
            end
        end
    end
endmodule

// File: rtl/ppa_add_arbiter.sv
// ppa_add_arbiter: round-robin sharing of one Sklansky adder with a registered response slot.
// Define PPA_ARB_CHAIN_EN to enable multi-beat carry chaining with a per-requester lock.
module ppa_add_arbiter
    import ppa_arb_pkg::*;
#(
    parameter  int W    = PPA_W,
    parameter  int NREQ = 4,
    localparam int IDW  = ppa_idw(NREQ)
) (
    input logic clk,
    input logic rst_n,
    ppa_add_arbiter_if.slave bus
);
    logic [NREQ-1:0] w_req, w_grant;
    logic [IDW-1:0]  w_id, w_ptr, w_ptr_nxt, r_ptr;
    logic            w_any, w_slot_free, w_xfer, w_cin, w_cout, w_hold_ptr, w_unused_id;
    logic [W-1:0]    w_a, w_b, w_sum;
    logic            r_valid;
    ppa_rsp_t        r_rsp;

    assign w_slot_free   = ~r_valid | bus.rsp_ready;
    assign w_xfer        = w_any & w_slot_free;
    assign bus.req_ready = w_grant & {NREQ{w_slot_free}};
    assign w_ptr_nxt     = (w_id == IDW'(NREQ - 1)) ? '0 : w_id + 1'b1;
    assign w_a           = bus.req_a[w_id*W +: W];
    assign w_b           = bus.req_b[w_id*W +: W];

`ifdef PPA_ARB_CHAIN_EN
    logic           r_lock, r_chain_c;
    logic [IDW-1:0] r_lock_id;

    assign w_req      = r_lock ? (bus.req_valid & (NREQ'(1) << r_lock_id)) : bus.req_valid;
    assign w_ptr      = r_lock ? r_lock_id : r_ptr;
    assign w_cin      = r_lock ? r_chain_c : bus.req_cin[w_id];
    assign w_hold_ptr = bus.req_chain[w_id];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_lock    <= 1'b0;
            r_lock_id <= '0;
            r_chain_c <= 1'b0;
        end else if (w_xfer) begin
            r_lock    <= bus.req_chain[w_id];
            r_lock_id <= w_id;
            r_chain_c <= w_cout;
        end
`else
    logic w_unused_chain;

    assign w_req          = bus.req_valid;
    assign w_ptr          = r_ptr;
    assign w_cin          = bus.req_cin[w_id];
    assign w_hold_ptr     = 1'b0;
    assign w_unused_chain = ^bus.req_chain;
`endif

    ppa_rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_rr (
        .i_req   (w_req),
        .i_ptr   (w_ptr),
        .o_grant (w_grant),
        .o_id    (w_id),
        .o_any   (w_any)
    );

    PPA_Sklansky_49bit u_add (
        .i_a    (w_a),
        .i_b    (w_b),
        .i_cin  (w_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            r_ptr <= '0;
        else if (w_xfer && !w_hold_ptr)
            r_ptr <= w_ptr_nxt;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_rsp   <= '0;
        end else if (w_xfer) begin
            r_valid <= 1'b1;
            r_rsp   <= '{id: PPA_IDW_MAX'(w_id), sum: w_sum, cout: w_cout};
        end else if (bus.rsp_ready) begin
            r_valid <= 1'b0;
        end

    assign bus.rsp_valid = r_valid;
    assign bus.rsp_id    = r_rsp.id[IDW-1:0];
    assign bus.rsp_sum   = r_rsp.sum;
    assign bus.rsp_cout  = r_rsp.cout;
    assign w_unused_id   = |(r_rsp.id >> IDW);
endmodule

// File: tb/tb_ppa_add_arbiter.sv
// tb_ppa_add_arbiter: randomized and directed scoreboard bench for ppa_add_arbiter.
module tb_ppa_add_arbiter;
    import ppa_arb_pkg::*;
    localparam int W = 49, NREQ = 4, IDW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ppa_add_arbiter_if #(.W(W), .NREQ(NREQ), .IDW(IDW)) bus();
    ppa_add_arbiter #(.W(W), .NREQ(NREQ)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        int           id;
        logic [W-1:0] sum;
        logic         cout;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   m_ptr, m_lock_id;
    bit   m_valid, m_lock, m_cc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        sb.delete();
        m_ptr = 0; m_valid = 0; m_lock = 0; m_lock_id = 0; m_cc = 0;
    endtask

    function automatic logic [W-1:0] pick();
        int s = $urandom_range(0, 3);
        return (s == 0) ? '1 : (s == 1) ? W'(1) : W'({$urandom, $urandom});
    endfunction

    task automatic rnd_ops();
        for (int i = 0; i < NREQ; i++) begin
            bus.req_a[i*W +: W] = pick();
            bus.req_b[i*W +: W] = pick();
        end
        bus.req_cin = NREQ'($urandom);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // reference: decide the next edge's transfer from the rules, then advance the model
    always @(negedge clk) if (rst_n) begin
        int              g;
        logic [NREQ-1:0] elig, exp_rdy;
        logic [W:0]      r;
        bit              free;
        chk("rsp_valid", bus.rsp_valid, m_valid);
        free = !m_valid || bus.rsp_ready;
        elig = bus.req_valid;
        if (m_lock) elig = elig & (NREQ'(1) << m_lock_id);
        g = -1;
        for (int k = 0; k < NREQ; k++)
            if (g < 0 && elig[(m_ptr + k) % NREQ]) g = (m_ptr + k) % NREQ;
        exp_rdy = (free && g >= 0) ? NREQ'(1) << g : '0;
        chk("req_ready", bus.req_ready, exp_rdy);
        if (free && g >= 0) begin
            r = {1'b0, bus.req_a[g*W +: W]} + {1'b0, bus.req_b[g*W +: W]} + (W+1)'(m_lock ? m_cc : bus.req_cin[g]);
            sb.push_back('{g, r[W-1:0], r[W]});
            m_valid = 1;
`ifdef PPA_ARB_CHAIN_EN
            m_lock    = bus.req_chain[g];
            m_lock_id = g;
            m_cc      = r[W];
            if (!m_lock) m_ptr = (g + 1) % NREQ;
`else
            m_ptr = (g + 1) % NREQ;
`endif
        end else if (bus.rsp_ready) begin
            m_valid = 0;
        end
    end

    // monitor: every presented response must match the oldest expectation
    always @(negedge clk) if (rst_n && bus.rsp_valid) begin
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL rsp_unexpected actual id=%0d required=no response", bus.rsp_id);
        end else begin
            chk("rsp_id", bus.rsp_id, sb[0].id);
            chk("rsp_sum", bus.rsp_sum, sb[0].sum);
            chk("rsp_cout", bus.rsp_cout, sb[0].cout);
            if (bus.rsp_ready) void'(sb.pop_front());
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

    initial begin
        int   beat, ng;
        int   gl[3];
        bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0;
        bus.req_cin = '0; bus.req_chain = '0; bus.rsp_ready = 1'b0;
        model_reset();
        #1;
        chk("reset_valid", bus.rsp_valid, 0);
        chk("reset_sum", bus.rsp_sum, 0);
        chk("reset_cout", bus.rsp_cout, 0);
        chk("reset_id", bus.rsp_id, 0);
        chk("reset_ready", bus.req_ready, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // single request, carry overflow into cout
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b0100;
        bus.req_a[2*W +: W] = 49'h1_FFFF_FFFF_FFFF;
        bus.req_b[2*W +: W] = 49'h1;
        cyc();
        chk("basic_valid", bus.rsp_valid, 1);
        chk("basic_id", bus.rsp_id, 2);
        chk("basic_sum", bus.rsp_sum, 0);
        chk("basic_cout", bus.rsp_cout, 1);
        bus.req_valid = 4'b1001;
        #1 chk("ptr_after_basic", bus.req_ready, 4'b1000);
        cyc();

        // full contention rotates 0..3 twice
        for (int i = 0; i < 8; i++) begin
            rnd_ops();
            bus.req_valid = '1;
            #1 chk("rr_grant", bus.req_ready, NREQ'(1) << (i % NREQ));
            cyc();
        end

        // backpressure, then same-cycle consume and reload
        bus.rsp_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rnd_ops();
            #1 chk("bp_ready", bus.req_ready, 0);
            cyc();
        end
        bus.rsp_ready = 1'b1;
        bus.req_valid = 4'b0010;
        #1 chk("bp_reload", bus.req_ready, 4'b0010);
        cyc();
        chk("no_bubble", bus.rsp_valid, 1);
        chk("reload_id", bus.rsp_id, 1);
        bus.req_valid = '0;
        cyc();

        // asynchronous reset mid-cycle with a pending response
        bus.rsp_ready = 1'b0;
        bus.req_valid = 4'b1000;
        rnd_ops();
        cyc();
        bus.req_valid = '0;
        chk("pre_reset_valid", bus.rsp_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_valid", bus.rsp_valid, 0);
        chk("async_rst_sum", bus.rsp_sum, 0);
        model_reset();
        bus.req_valid = 4'b1001;
        bus.rsp_ready = 1'b1;
        cyc();
        rst_n = 1'b1;
        #1 chk("post_reset_grant", bus.req_ready, 4'b0001);
        cyc();
        bus.req_valid = '0;
        cyc();

        // two-beat chained add from requester 1 against a always-valid requester 0
        beat = 0;
        ng = 0;
        bus.req_a[W +: W] = '1;
        bus.req_b[W +: W] = W'(1);
        bus.req_cin = '0;
        for (int n = 0; n < 12 && ng < 3; n++) begin
            bus.req_a[0 +: W] = pick();
            bus.req_b[0 +: W] = pick();
            bus.req_valid = {2'b00, beat < 2, 1'b1};
            bus.req_chain = {2'b00, beat == 0, 1'b0};
            #1;
            if (bus.req_ready[1]) begin gl[ng] = 1; ng++; beat++; end
            else if (bus.req_ready[0]) begin gl[ng] = 0; ng++; end
            cyc();
        end
        chk("chain_grants", ng, 3);
`ifdef PPA_ARB_CHAIN_EN
        chk("chain_order", {gl[0][1:0], gl[1][1:0], gl[2][1:0]}, {2'd1, 2'd1, 2'd0});
`else
        chk("chain_order", {gl[0][1:0], gl[1][1:0], gl[2][1:0]}, {2'd1, 2'd0, 2'd1});
`endif
        bus.req_valid = '0;
        bus.req_chain = '0;
        cyc();

        // randomized traffic with random backpressure
        repeat (400) begin
            rnd_ops();
            bus.req_valid = NREQ'($urandom);
            bus.req_chain = NREQ'($urandom) & NREQ'($urandom);
            bus.rsp_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        bus.req_valid = '0;
        bus.req_chain = '0;
        bus.rsp_ready = 1'b1;
        repeat (3) cyc();
        chk("sb_drained", sb.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
